// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Synchronizes RX_IN, qualifies the start bit, samples each bit mid-period,
// checks optional parity and the stop bit, and reports the received word.
// Ports:
//   clk        oversampling clock, PRESCALE cycles per bit
//   rst        asynchronous active-high reset
//   RX_IN      serial line, idle high, LSB first, asynchronous to clk
//   PAR_TYP    0 = even parity, 1 = odd parity
//   P_DATA     last received word (loaded even when the frame has errors)
//   data_valid one-cycle pulse, P_DATA holds a good frame
//   par_err    one-cycle pulse, parity mismatch
//   stp_err    one-cycle pulse, stop bit sampled low
//   busy_flag  high while a frame is being received
// Optional build macro UART_RX_MAJORITY_EN: bit value is the 2-of-3 majority
// of three samples around mid-bit instead of a single mid-bit sample.
module uart_rx #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PAR_EN     = 1,
   parameter int unsigned PRESCALE   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy_flag
);

   localparam int unsigned CNT_W = $clog2(PRESCALE);
   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] EDGE_MID  = CNT_W'(PRESCALE / 2);
   localparam logic [CNT_W-1:0] EDGE_DEC  = CNT_W'(PRESCALE / 2 + 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'b000,
      S_START  = 3'b001,
      S_DATA   = 3'b011,
      S_PARITY = 3'b010,
      S_STOP   = 3'b110
   } state_t;

   logic                  sync1_q;
   logic                  rx_s_q;
   logic                  samp_mid_q;
   logic                  bit_d;
   state_t                state_q;
   logic [CNT_W-1:0]      edge_cnt_q;
   logic [BIT_W-1:0]      bit_cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  par_bad_q;
   logic [DATA_WIDTH-1:0] p_data_q;
   logic                  data_valid_q;
   logic                  par_err_q;
   logic                  stp_err_q;
   logic                  busy_q;

   // Two-flop synchronizer (idle-high reset) and mid-bit sample capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         samp_mid_q <= 1'b1;
      end else begin
         sync1_q <= RX_IN;
         rx_s_q  <= sync1_q;
         if (edge_cnt_q == EDGE_MID) samp_mid_q <= rx_s_q;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   localparam logic [CNT_W-1:0] EDGE_EARLY = CNT_W'(PRESCALE / 2 - 1);
   logic samp_early_q;

   // Earliest of the three votes; the third vote is the live sample at the decision point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_early_q <= 1'b1;
      end else if (edge_cnt_q == EDGE_EARLY) begin
         samp_early_q <= rx_s_q;
      end
   end

   assign bit_d = (samp_early_q & samp_mid_q) | (samp_early_q & rx_s_q) | (samp_mid_q & rx_s_q);
`else
   assign bit_d = samp_mid_q;
`endif

   // Frame FSM with counters, shift register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         edge_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_bad_q    <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         busy_q       <= (state_q != S_IDLE);
         edge_cnt_q   <= edge_cnt_q + CNT_W'(1);
         unique case (state_q)
            S_IDLE: begin
               edge_cnt_q <= '0;
               bit_cnt_q  <= '0;
               if (!rx_s_q) begin
                  state_q   <= S_START;
                  par_bad_q <= 1'b0;
               end
            end
            S_START: begin
               // A high sample at the decision point means the low was a glitch.
               if (edge_cnt_q == EDGE_DEC && bit_d) begin
                  state_q    <= S_IDLE;
                  edge_cnt_q <= '0;
               end else if (edge_cnt_q == EDGE_LAST) begin
                  state_q    <= S_DATA;
                  edge_cnt_q <= '0;
               end
            end
            S_DATA: begin
               if (edge_cnt_q == EDGE_DEC) shift_q <= {bit_d, shift_q[DATA_WIDTH-1:1]};
               if (edge_cnt_q == EDGE_LAST) begin
                  edge_cnt_q <= '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_q <= '0;
                     state_q   <= (PAR_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                  end
               end
            end
            S_PARITY: begin
               // Received parity bit must equal XOR of data, inverted for odd parity.
               if (edge_cnt_q == EDGE_DEC) par_bad_q <= bit_d ^ (^shift_q) ^ PAR_TYP;
               if (edge_cnt_q == EDGE_LAST) begin
                  state_q    <= S_STOP;
                  edge_cnt_q <= '0;
               end
            end
            S_STOP: begin
               // Leave mid-stop-bit so a following start bit is not missed.
               if (edge_cnt_q == EDGE_DEC) begin
                  state_q      <= S_IDLE;
                  edge_cnt_q   <= '0;
                  p_data_q     <= shift_q;
                  data_valid_q <= bit_d & ~par_bad_q;
                  par_err_q    <= par_bad_q;
                  stp_err_q    <= ~bit_d;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               edge_cnt_q <= '0;
            end
         endcase
      end
   end

   assign P_DATA     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;
   assign busy_flag  = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (DATA_WIDTH 8, PAR_EN 1, PRESCALE 8).
// A frame-level model predicts, for each frame sent, the cycle of the result
// pulse and the word/flags it carries; a monitor collects the DUT's pulses.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DW    = 8;
   localparam int PEN   = 1;
   localparam int PS    = 8;
   localparam int NBITS = DW + 2 + PEN;
   localparam int LAT   = 3 + (NBITS - 1) * PS + PS / 2 + 1;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       dv;
      logic       pe;
      logic       se;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic       par_typ;
   logic [7:0] p_data;
   logic       dv, pe, se, busy;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   rise_cyc = -1;
   int   fall_cyc = -1;
   logic busy_prev = 1'b0;
   rec_t obs_q[$];
   rec_t exp_q[$];

   uart_rx #(.DATA_WIDTH(DW), .PAR_EN(PEN), .PRESCALE(PS)) dut (
      .clk        (clk),
      .rst        (rst),
      .RX_IN      (rx_in),
      .PAR_TYP    (par_typ),
      .P_DATA     (p_data),
      .data_valid (dv),
      .par_err    (pe),
      .stp_err    (se),
      .busy_flag  (busy)
   );

   always #5 clk = ~clk;

   // cyc equals the index of the most recent rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Collect result pulses and busy transitions away from the active edge.
   always @(negedge clk) begin
      rec_t r;
      if (!rst && (dv || pe || se)) begin
         r.cyc  = cyc;
         r.data = p_data;
         r.dv   = dv;
         r.pe   = pe;
         r.se   = se;
         obs_q.push_back(r);
      end
      if (busy && !busy_prev) rise_cyc = cyc;
      if (!busy && busy_prev) fall_cyc = cyc;
      busy_prev = busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one frame starting at the current negedge; k_o is the first sync capture edge.
   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                             input int gap, input int g_bit, input int g_off, output int k_o);
      logic [10:0] fb;
      rec_t        e;
      fb    = {~bad_stop, (^d) ^ par_typ ^ bad_par, d, 1'b0};
      k_o   = cyc + 1;
      e.cyc  = k_o + LAT;
      e.data = d;
      e.dv   = !bad_par && !bad_stop;
      e.pe   = bad_par;
      e.se   = bad_stop;
      exp_q.push_back(e);
      for (int i = 0; i < NBITS; i++) begin
         rx_in = fb[i];
         for (int c = 0; c < PS; c++) begin
            @(negedge clk);
            if (i == g_bit && c < PS - 1) rx_in = (c == g_off) ? ~fb[i] : fb[i];
         end
      end
      rx_in = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic compare_batch(input string tag);
      rec_t e, o;
      chk({tag, ".count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk({tag, ".cycle"}, o.cyc, e.cyc);
         chk({tag, ".p_data"}, o.data, e.data);
         chk({tag, ".data_valid"}, o.dv, e.dv);
         chk({tag, ".par_err"}, o.pe, e.pe);
         chk({tag, ".stp_err"}, o.se, e.se);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic check_batch(input string tag);
      repeat (3 * PS) @(negedge clk);
      compare_batch(tag);
   endtask

   initial begin
      int          k;
      logic [7:0]  d;
      logic [10:0] fb;
      bit          bp, bs;
      rec_t        e;

      rst = 1'b1; rx_in = 1'b1; par_typ = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.p_data", p_data, 0);
      chk("reset.data_valid", dv, 0);
      chk("reset.par_err", pe, 0);
      chk("reset.stp_err", se, 0);
      chk("reset.busy", busy, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle.busy", busy, 0);

      // Nominal frame with even parity.
      par_typ = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0, 2 * PS, -1, 0, k);
      check_batch("nominal");
      chk("nominal.busy_rise", rise_cyc, k + 3);
      chk("nominal.busy_fall", fall_cyc, k + LAT + 1);
      chk("nominal.p_data_hold", p_data, 8'hA5);

      // Three-cycle low on the line: start rejected.
      k = cyc + 1;
      rx_in = 1'b0;
      repeat (3) @(negedge clk);
      rx_in = 1'b1;
      repeat (4 * PS) @(negedge clk);
      chk("glitch.pulses", obs_q.size(), 0);
      chk("glitch.busy_rise", rise_cyc, k + 3);
      chk("glitch.busy", busy, 0);
      chk("glitch.p_data", p_data, 8'hA5);

      // Odd parity with the wrong parity bit.
      par_typ = 1'b1;
      send_frame(8'h3C, 1'b1, 1'b0, 2 * PS, -1, 0, k);
      check_batch("par_err");

      // Stop error, then a clean frame.
      par_typ = 1'b0;
      send_frame(8'h55, 1'b0, 1'b1, 2 * PS, -1, 0, k);
      send_frame(8'h0F, 1'b0, 1'b0, 2 * PS, -1, 0, k);
      check_batch("stp_err");

      // Back-to-back frames with no idle gap.
      send_frame(8'h01, 1'b0, 1'b0, 0, -1, 0, k);
      send_frame(8'hFE, 1'b0, 1'b0, 2 * PS, -1, 0, k);
      check_batch("b2b");

      // Random frames, parity types, errors and gaps.
      for (int n = 0; n < 8; n++) begin
         d       = 8'($urandom);
         par_typ = 1'($urandom);
         bp      = ($urandom_range(3) == 0);
         bs      = ($urandom_range(3) == 0);
         send_frame(d, bp, bs, bs ? 2 * PS : int'($urandom_range(PS)), -1, 0, k);
      end
      check_batch("random");

      // Reset in the middle of data bit 4.
      par_typ = 1'b0;
      d  = 8'h96;
      fb = {1'b1, ^d, d, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx_in = fb[i];
         repeat (PS) @(negedge clk);
      end
      rx_in = fb[5];
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      rx_in = 1'b1;
      #1;
      chk("midrst.p_data", p_data, 0);
      chk("midrst.data_valid", dv, 0);
      chk("midrst.par_err", pe, 0);
      chk("midrst.stp_err", se, 0);
      chk("midrst.busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2 * PS) @(negedge clk);
      chk("midrst.no_pulse", obs_q.size(), 0);
      send_frame(8'hC3, 1'b0, 1'b0, 2 * PS, -1, 0, k);
      check_batch("after_rst");

`ifdef UART_RX_MAJORITY_EN
      // One-cycle inversion at edge_cnt 4 of data bit 2 is outvoted.
      send_frame(8'h5A, 1'b0, 1'b0, 2 * PS, 3, 4, k);
      check_batch("majority");
`endif

      // Line stuck low: stop-error frames repeat every frame time.
      par_typ = 1'b0;
      k = cyc + 1;
      rx_in = 1'b0;
      e.data = 8'h00; e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b1;
      e.cyc = k + LAT;
      exp_q.push_back(e);
      e.cyc = k + 2 * LAT - 1;
      exp_q.push_back(e);
      repeat (2 * LAT + 4) @(negedge clk);
      compare_batch("stuck_low");
      rst = 1'b1;
      rx_in = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("final.busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
